// File: rtl/phoenix_switch_control.sv
// Phoenix router switch control: round-robin header arbitration, XY routing, crossbar tables.
// Optional blocked-route counter port block_cnt enabled by `define SC_BLOCK_CNT_EN.
module phoenix_switch_control #(
   parameter int NPORT    = 5,
   parameter int TAM_FLIT = 16,
   parameter int ADDR_X   = 0,
   parameter int ADDR_Y   = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NPORT-1:0]          h,
   input  logic [NPORT-1:0]          sender,
   input  logic [NPORT*TAM_FLIT-1:0] data,
   output logic [NPORT-1:0]          ack_h,
   output logic [NPORT*3-1:0]        mux_in,
   output logic [NPORT*3-1:0]        mux_out,
   output logic [NPORT-1:0]          free
`ifdef SC_BLOCK_CNT_EN
   ,
   output logic [15:0]               block_cnt
`endif
);

   localparam logic [2:0] EAST   = 3'd0;
   localparam logic [2:0] WEST   = 3'd1;
   localparam logic [2:0] NORTH  = 3'd2;
   localparam logic [2:0] SOUTH  = 3'd3;
   localparam logic [2:0] LOCAL  = 3'd4;
   localparam logic [3:0] ADDR_X_L = 4'(ADDR_X);
   localparam logic [3:0] ADDR_Y_L = 4'(ADDR_Y);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARB   = 2'd1,
      S_ROUTE = 2'd2,
      S_GRANT = 2'd3
   } state_t;

   state_t            state_r;
   logic [2:0]        last_r;
   logic [2:0]        sel_r;
   logic [NPORT-1:0]  sender_q_r;
   logic [2:0]        next_sel_s;
   logic [7:0]        hdr_s;
   logic [2:0]        dst_s;

   // X first, then Y; equal coordinates deliver locally
   function automatic logic [2:0] xy_route(input logic [3:0] tx, input logic [3:0] ty);
      logic [2:0] port;
      if (tx > ADDR_X_L) begin
         port = EAST;
      end else if (tx < ADDR_X_L) begin
         port = WEST;
      end else if (ty > ADDR_Y_L) begin
         port = NORTH;
      end else if (ty < ADDR_Y_L) begin
         port = SOUTH;
      end else begin
         port = LOCAL;
      end
      return port;
   endfunction

   // Round-robin pick: descending scan leaves the nearest requester after last_r
   always_comb begin
      logic [2:0] idx;
      idx        = 3'd0;
      next_sel_s = last_r;
      for (int k = NPORT; k >= 1; k--) begin
         idx        = 3'((int'(last_r) + k) % NPORT);
         next_sel_s = h[idx] ? idx : next_sel_s;
      end
   end

   // Destination of the header at the head of the selected buffer
   always_comb begin
      hdr_s = data[int'(sel_r)*TAM_FLIT +: 8];
      dst_s = xy_route(hdr_s[7:4], hdr_s[3:0]);
   end

   // Arbitration FSM, crossbar tables and end-of-packet release
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= S_IDLE;
         last_r     <= LOCAL;
         sel_r      <= 3'd0;
         sender_q_r <= {NPORT{1'b0}};
         ack_h      <= {NPORT{1'b0}};
         free       <= {NPORT{1'b1}};
         mux_in     <= {(NPORT*3){1'b0}};
         mux_out    <= {(NPORT*3){1'b0}};
`ifdef SC_BLOCK_CNT_EN
         block_cnt  <= 16'h0000;
`endif
      end else begin
         sender_q_r <= sender;
         ack_h      <= {NPORT{1'b0}};
         // A falling sender frees whatever output that input held
         for (int i = 0; i < NPORT; i++) begin
            if (sender_q_r[i] && !sender[i]) begin
               free[mux_out[i*3 +: 3]] <= 1'b1;
            end
         end
         case (state_r)
            S_IDLE: begin
               if (|h) begin
                  state_r <= S_ARB;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_ARB: begin
               if (|h) begin
                  sel_r   <= next_sel_s;
                  last_r  <= next_sel_s;
                  state_r <= S_ROUTE;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_ROUTE: begin
               if (free[dst_s]) begin
                  free[dst_s]                    <= 1'b0;
                  mux_in[int'(dst_s)*3 +: 3]     <= sel_r;
                  mux_out[int'(sel_r)*3 +: 3]    <= dst_s;
                  ack_h[sel_r]                   <= 1'b1;
                  state_r                        <= S_GRANT;
               end else begin
`ifdef SC_BLOCK_CNT_EN
                  if (block_cnt != 16'hFFFF) begin
                     block_cnt <= block_cnt + 16'd1;
                  end else begin
                     block_cnt <= block_cnt;
                  end
`endif
                  state_r <= S_IDLE;
               end
            end
            S_GRANT: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phoenix_switch_control.sv
// Directed bench for phoenix_switch_control at router address (1,1).
module tb_phoenix_switch_control;

   localparam int NPORT = 5;
   localparam int TF    = 16;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic [NPORT-1:0]       h = '0;
   logic [NPORT-1:0]       sender = '0;
   logic [NPORT*TF-1:0]    data = '0;
   logic [NPORT-1:0]       ack_h;
   logic [NPORT*3-1:0]     mux_in;
   logic [NPORT*3-1:0]     mux_out;
   logic [NPORT-1:0]       free;
`ifdef SC_BLOCK_CNT_EN
   logic [15:0]            block_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   phoenix_switch_control #(.NPORT(NPORT), .TAM_FLIT(TF), .ADDR_X(1), .ADDR_Y(1)) dut (
      .clock   (clock),
      .reset   (reset),
      .h       (h),
      .sender  (sender),
      .data    (data),
      .ack_h   (ack_h),
      .mux_in  (mux_in),
      .mux_out (mux_out),
      .free    (free)
`ifdef SC_BLOCK_CNT_EN
      ,
      .block_cnt (block_cnt)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_hdr(input int i, input logic [15:0] v);
      data[i*TF +: TF] = v;
   endtask

   function automatic logic [2:0] fld(input logic [NPORT*3-1:0] v, input int k);
      return v[k*3 +: 3];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      tick(); tick();
      reset = 1'b0;
      chk("rst_free", 32'(free), 32'h1F);
      chk("rst_ack", 32'(ack_h), 32'h0);
      chk("rst_mux_in", 32'(mux_in), 32'h0);
      chk("rst_mux_out", 32'(mux_out), 32'h0);

      // single request from LOCAL heading east
      h = 5'b10000; set_hdr(4, 16'h0021);
      tick(); chk("t1_ack_arb", 32'(ack_h), 32'h0);
      tick(); chk("t1_ack_route", 32'(ack_h), 32'h0);
      tick(); chk("t1_ack", 32'(ack_h), 32'h10);
      chk("t1_free", 32'(free), 32'h1E);
      chk("t1_mux_in0", 32'(fld(mux_in, 0)), 32'd4);
      chk("t1_mux_out4", 32'(fld(mux_out, 4)), 32'd0);
      h = 5'b00000;
      tick(); chk("t1_ack_pulse", 32'(ack_h), 32'h0);
      sender = 5'b10000; tick();
      sender = 5'b00000; tick();
      chk("t1_release", 32'(free), 32'h1F);

      // local delivery from EAST input
      h = 5'b00001; set_hdr(0, 16'h0011);
      tick(); tick(); tick();
      chk("t2_ack", 32'(ack_h), 32'h01);
      chk("t2_mux_out0", 32'(fld(mux_out, 0)), 32'd4);
      chk("t2_free", 32'(free), 32'h0F);
      h = 5'b00000;

      // round robin: 0, then 2, then 0 again after its release
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t3_rst_free", 32'(free), 32'h1F);
      h = 5'b00101; set_hdr(0, 16'h0021); set_hdr(2, 16'h0012);
      tick(); tick(); tick();
      chk("t3_ack_a", 32'(ack_h), 32'h01);
      h = 5'b00100; sender = 5'b00001;
      tick(); chk("t3_idle_ack", 32'(ack_h), 32'h0);
      tick(); tick();
      chk("t3_route_ack", 32'(ack_h), 32'h0);
      tick(); chk("t3_ack_b", 32'(ack_h), 32'h04);
      chk("t3_free_b", 32'(free), 32'h1A);
      h = 5'b00000; sender = 5'b00101;
      tick();
      sender = 5'b00100;
      tick(); chk("t3_release0", 32'(free), 32'h1B);
      h = 5'b00001;
      tick(); tick(); tick();
      chk("t3_ack_c", 32'(ack_h), 32'h01);
      chk("t3_free_c", 32'(free), 32'h1A);
      h = 5'b00000;

      // block then release
      reset = 1'b1; tick(); reset = 1'b0; sender = 5'b00000;
      h = 5'b01000; set_hdr(3, 16'h0021);
      tick(); tick(); tick();
      chk("t4_ack3", 32'(ack_h), 32'h08);
      h = 5'b00000; sender = 5'b01000;
      tick();
      h = 5'b00010; set_hdr(1, 16'h0021);
      tick(); tick(); tick();
      chk("t4_blocked_ack", 32'(ack_h), 32'h0);
      chk("t4_blocked_free", 32'(free), 32'h1E);
`ifdef SC_BLOCK_CNT_EN
      chk("t4_block_cnt", 32'(block_cnt), 32'd1);
`endif
      sender = 5'b00000;
      tick(); chk("t4_release", 32'(free), 32'h1F);
      tick(); chk("t4_route_ack", 32'(ack_h), 32'h0);
      tick(); chk("t4_ack1", 32'(ack_h), 32'h02);
      chk("t4_mux_in0", 32'(fld(mux_in, 0)), 32'd1);
      chk("t4_free", 32'(free), 32'h1E);
      h = 5'b00000;
`ifdef SC_BLOCK_CNT_EN
      chk("t4_block_cnt_hold", 32'(block_cnt), 32'd1);
`endif

      // simultaneous release of NORTH and allocation of WEST
      reset = 1'b1; tick(); reset = 1'b0;
`ifdef SC_BLOCK_CNT_EN
      chk("t5_block_cnt_rst", 32'(block_cnt), 32'd0);
`endif
      h = 5'b00100; set_hdr(2, 16'h0012);
      tick(); tick(); tick();
      chk("t5_ack2", 32'(ack_h), 32'h04);
      chk("t5_free_n", 32'(free), 32'h1B);
      h = 5'b00000; sender = 5'b00100;
      tick();
      h = 5'b10000; set_hdr(4, 16'h0001);
      tick(); tick();
      sender = 5'b00000;
      tick();
      chk("t5_free_both", 32'(free), 32'h1D);
      chk("t5_ack4", 32'(ack_h), 32'h10);
      chk("t5_mux_out4", 32'(fld(mux_out, 4)), 32'd1);
      chk("t5_mux_in1", 32'(fld(mux_in, 1)), 32'd4);

      // reset while in ROUTE drops everything and the pending grant
      h = 5'b00000;
      tick();
      h = 5'b00001; set_hdr(0, 16'h0010);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_free", 32'(free), 32'h1F);
      chk("t6_ack", 32'(ack_h), 32'h0);
      chk("t6_mux_in", 32'(mux_in), 32'h0);
      tick(); chk("t6_arb_ack", 32'(ack_h), 32'h0);
      tick(); chk("t6_route_ack", 32'(ack_h), 32'h0);
      tick(); chk("t6_ack", 32'(ack_h), 32'h01);
      chk("t6_free_s", 32'(free), 32'h17);
      chk("t6_mux_out0", 32'(fld(mux_out, 0)), 32'd3);
      h = 5'b00000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phoenix_switch_control.md
Name: phoenix_switch_control

Overview:
- Central routing/arbitration controller of one Phoenix router.
- Watches the header-request line `h` of the NPORT input buffers and picks one requester per decision with round-robin priority.
- Computes the XY route from the header flit at the buffer head. If the chosen output port is free, it acknowledges the buffer (`ack_h`) and programs the crossbar selection tables.
- Frees the output again when the buffer's `sender` line falls at end of packet.

Parameters:
- NPORT, 5, number of router ports. Fixed index map: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- TAM_FLIT, 16, flit width in bits.
- ADDR_X, 0, X coordinate of this router (4 bits).
- ADDR_Y, 0, Y coordinate of this router (4 bits).

Ports:
- clock  in  1  router clock.
- reset  in  1  synchronous, active-high.
- h  in  NPORT  per-input header request from the buffer.
- sender  in  NPORT  per-input "packet in transfer" from the buffer.
- data  in  NPORT*TAM_FLIT  flattened buffer-head flits; input i occupies bits [i*TAM_FLIT +: TAM_FLIT].
- ack_h  out  NPORT  one-hot routing acknowledge, 1-cycle pulse.
- mux_in  out  NPORT*3  per output o: index of the input driving o.
- mux_out  out  NPORT*3  per input i: index of the output i is connected to.
- free  out  NPORT  per output: 1 = unallocated.

Behaviour:
- Reset:
  - State goes to S_IDLE; `ack_h`=0; `free`=all 1; `mux_in`=0; `mux_out`=0.
  - Round-robin pointer `last`=LOCAL (4), so input 0 has first priority.
- Header target field: data[i][7:4]=TX, data[i][3:0]=TY. Upper flit bits are ignored.
- XY routing:
  - TX>ADDR_X → EAST; TX<ADDR_X → WEST.
  - Otherwise TY>ADDR_Y → NORTH; TY<ADDR_Y → SOUTH.
  - Otherwise LOCAL.
  - Compares are 4-bit unsigned.
- State machine (registered state, one transition per clock):
  - S_IDLE: if any h bit is 1 → S_ARB.
  - S_ARB: `sel` = first i with h[i]=1, searching from last+1 upward modulo NPORT; `last`<=sel; → S_ROUTE.
    - If h has dropped to all 0 in this cycle → S_IDLE, with `last` unchanged.
  - S_ROUTE: compute `dst` from data[sel].
    - If free[dst]=1: free[dst]<=0, mux_in[dst]<=sel, mux_out[sel]<=dst; → S_GRANT.
    - If free[dst]=0 (blocked): no table change; → S_IDLE. `last` has already advanced, so the other requesters are served first.
  - S_GRANT: ack_h[sel]=1 for exactly this cycle, all other bits 0; → S_IDLE.
- Latency: h rising in S_IDLE gives ack_h in the 4th cycle after (IDLE→ARB→ROUTE→GRANT). Minimum 4 cycles between two grants.
- Release:
  - `sender_q` is `sender` registered.
  - On any cycle with sender_q[i]=1 and sender[i]=0: free[mux_out[i]]<=1.
  - Releases are independent of the FSM state and may hit several inputs in one cycle.
  - `mux_in`/`mux_out` keep stale values after release; consumers qualify them with `free`.
- Simultaneous release and allocation on the same edge:
  - Different outputs: both applied.
  - Same output: impossible, because ROUTE sees the pre-edge `free`=0 and reports blocked. The retry on a later arbitration succeeds.
- Input whose h stays high while blocked: re-requests via IDLE. No starvation, because the pointer rotates.
- Reset asserted mid-operation: all allocations are dropped at the next edge, and any pending grant is lost (ack_h=0).
- U-turn (dst == sel, e.g. local-to-local): allowed, no special case.

Optional Feature:
- Macro SC_BLOCK_CNT_EN.
- When defined:
  - Extra output port `block_cnt` (out, 16 bits).
  - Increments by 1 on every S_ROUTE cycle that finds free[dst]=0, and saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Single request, ADDR=(1,1): h=5'b10000, data[4]=8'h21 → ack_h=5'b10000 exactly 4 cycles after h; free[0]=0; mux_in[0]=4; mux_out[4]=0.
- Local delivery: h[0]=1, data[0]=8'h11 → ack_h[0] pulse; mux_out[0]=4; free[4]=0.
- Round robin: h=5'b00101 held, targets EAST (8'h21) and NORTH (8'h12), releases via sender → grants in order input 0, then 2, then 0 again after its release.
- Block/release: input 3 holds EAST; input 1 requests EAST → no ack (block_cnt=1 with SC_BLOCK_CNT_EN). sender[3] 1→0 → free[0]=1 next cycle; input 1 granted on its next arbitration.
- Simultaneous: sender[2] falls on the same edge as input 4 is allocated WEST → both free[release]=1 and free[1]=0 after the edge.
- Reset mid-grant: assert reset during S_ROUTE → next cycle free=5'b11111, ack_h=0, state S_IDLE.
